lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
- Shared-bus controller for the HD44780-style character display (RS/RW/E/DB[7:0]).
- Arbitrates between two byte requesters: requester 0 is the config/init engine, requester 1 is the phrase/text writer.
- Serialises each accepted byte into a timed write cycle (setup, E pulse, hold, execution wait), so requesters never handle display timing.

Parameters:
- T_SETUP_CYC, 2: cycles RS/DB are stable before E rises.
- T_EPW_CYC, 12: cycles E stays high.
- T_HOLD_CYC, 2: cycles RS/DB are held after E falls.
- T_EXEC_CYC, 2000: post-write wait for normal commands and data (about 40 us at 50 MHz).
- T_LONG_CYC, 82000: post-write wait for clear/return-home (about 1.64 ms at 50 MHz).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  requester 0: 0 = command, 1 = data.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 transfer accepted this cycle when valid & ready.
- req1_valid  in  1  requester 1 has a byte.
- req1_rs  in  1  requester 1: 0 = command, 1 = data.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 transfer accepted when valid & ready.
- RS  out  1  display register select.
- RW  out  1  display read/write; always 0 (write-only).
- E  out  1  display enable strobe.
- DB  out  8  display data bus.
- busy  out  1  high while a write cycle is in progress (any state other than IDLE).
- grant_id  out  1  requester owning the current or last cycle.

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high. All outputs are registered except req0_ready and req1_ready.
- Reset values: RS=0, RW=0, E=0, DB=0x00, busy=0, grant_id=0, state=IDLE, counter=0, starvation counter=0. reset overrides everything, including mid-pulse: E is 0 from the first edge with reset high. An in-flight byte is dropped, not retried.
- States: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE arbitration is fixed priority, requester 0 over requester 1.
  - req0_ready = IDLE & req0_valid.
  - req1_ready = IDLE & req1_valid & ~req0_valid.
  - Both readys are 0 in every other state.
- Accept edge: on the edge where valid & ready, latch rs and data into RS/DB, set grant_id and busy=1, load counter=T_SETUP_CYC-1, and go to SETUP.
- SETUP: E=0. When the counter reaches 0, go to PULSE and set E=1 with counter=T_EPW_CYC-1.
- PULSE: E=1. When the counter reaches 0, go to HOLD and set E=0 with counter=T_HOLD_CYC-1.
- HOLD: E=0, RS and DB unchanged. When the counter reaches 0, go to WAIT with counter=T_WAIT-1.
- T_WAIT selection: T_LONG_CYC if the latched rs==0 and data is in {0x01, 0x02, 0x03}; otherwise T_EXEC_CYC. Byte 0x00 is short.
- WAIT: when the counter reaches 0, go to IDLE with busy=0. RS/DB keep their last value until the next accept.
- Timing for an accept at edge t:
  - E rises at t+T_SETUP_CYC.
  - E falls at t+T_SETUP_CYC+T_EPW_CYC.
  - IDLE is reached at t+T_SETUP_CYC+T_EPW_CYC+T_HOLD_CYC+T_WAIT.
  - The next accept can occur on the edge after IDLE is entered.
  - Defaults give 2016 cycles for a short byte and 82016 for a long byte.
- Requester signal changes outside the accept edge are ignored.
- The counter is sized by $clog2 of the largest parameter. All parameters must be ≥1; a value of 1 gives a single-cycle state.
- Back-to-back requests: no cycle is skipped or merged. Each accepted byte produces exactly one E pulse.

Optional Feature:
- Macro: LCD_SEQ_STARVE_GUARD_EN.
- Defined: a 2-bit counter increments on each requester-0 grant made while req1_valid=1, and clears on any requester-1 grant. When it reaches 3, the next IDLE arbitration with req1_valid=1 grants requester 1 even if req0_valid=1 (req0_ready=0 in that cycle), then the counter clears.
- Not defined: strict priority. The counter logic is absent and requester 1 can starve indefinitely.

Test Plan:
- Reset, then idle → RS=0, RW=0, E=0, DB=0x00, busy=0, both readys 0; assert reset mid-PULSE → E=0 after the next edge and state=IDLE.
- Use T_SETUP=2, T_EPW=4, T_HOLD=2, T_EXEC=20, T_LONG=100. Requester 1 sends rs=1, data=0x41 → E high for exactly 4 cycles starting 2 cycles after accept, DB=0x41 and RS=1 throughout, busy low 28 cycles after accept.
- Same parameters. Requester 0 sends rs=0, data=0x01 → 108-cycle cycle. Repeat with data=0x38 → 28 cycles. Repeat with rs=1, data=0x01 → 28 cycles.
- Both valid together in IDLE → requester 0 wins, req1_ready=0. Requester 1 is accepted on the edge after IDLE returns, provided req0_valid has dropped.
- Requester 0 held valid with 5 bytes and requester 1 valid throughout → macro undefined: 5 requester-0 grants before requester 1 is granted; macro defined: grant order 0,0,0,1,0,0.
- 10 back-to-back bytes from requester 1 → exactly 10 E pulses and no ready asserted while busy=1.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - two-requester arbiter and timed HD44780 write-cycle sequencer
// Optional: define LCD_SEQ_STARVE_GUARD_EN to force a requester-1 grant after three contested requester-0 grants.
module lcd_bus_sequencer #(
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EPW_CYC   = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_LONG_CYC  = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] DB,
    output logic       busy,
    output logic       grant_id
);

    localparam int unsigned T_MAX_A = (T_SETUP_CYC > T_EPW_CYC)  ? T_SETUP_CYC : T_EPW_CYC;
    localparam int unsigned T_MAX_B = (T_HOLD_CYC  > T_EXEC_CYC) ? T_HOLD_CYC  : T_EXEC_CYC;
    localparam int unsigned T_MAX_C = (T_MAX_A     > T_MAX_B)    ? T_MAX_A     : T_MAX_B;
    localparam int unsigned T_MAX   = (T_MAX_C     > T_LONG_CYC) ? T_MAX_C     : T_LONG_CYC;
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(T_EPW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             gid_q, gid_d;
    logic             idle;
    logic             cnt_zero;
    logic             long_wait;
    logic             force_req1;

    assign idle      = (state_q == S_IDLE);
    assign cnt_zero  = (cnt_q == '0);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign long_wait = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

`ifdef LCD_SEQ_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;

    assign force_req1 = (starve_q == 2'd3) && req1_valid;

    always_comb begin
        starve_d = starve_q;
        if (req0_ready && req0_valid && req1_valid) begin
            starve_d = starve_q + 2'd1;
        end else if (req1_ready && req1_valid) begin
            starve_d = 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_req1 = 1'b0;
`endif

    assign req0_ready = idle && req0_valid && !force_req1;
    assign req1_ready = idle && req1_valid && (!req0_valid || force_req1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        db_d    = db_q;
        e_d     = e_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    rs_d    = req0_rs;
                    db_d    = req0_data;
                    gid_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = LD_SETUP;
                    state_d = S_SETUP;
                end else if (req1_ready) begin
                    rs_d    = req1_rs;
                    db_d    = req1_data;
                    gid_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = LD_SETUP;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                e_d = 1'b0;
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    e_d     = 1'b1;
                    cnt_d   = LD_EPW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    e_d     = 1'b0;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = long_wait ? LD_LONG : LD_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                e_d     = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset wins over any in-flight cycle; the interrupted byte is simply lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
        end
    end

    assign RS       = rs_q;
    assign RW       = 1'b0;
    assign E        = e_q;
    assign DB       = db_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - directed vector bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;

    localparam int T_SETUP = 2;
    localparam int T_EPW   = 4;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 20;
    localparam int T_LONG  = 100;
    localparam int SHORT_LEN = T_SETUP + T_EPW + T_HOLD + T_EXEC;
    localparam int LONG_LEN  = T_SETUP + T_EPW + T_HOLD + T_LONG;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic       req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       RS, RW, E, busy, grant_id;
    logic [7:0] DB;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_bus_sequencer #(
        .T_SETUP_CYC(T_SETUP),
        .T_EPW_CYC  (T_EPW),
        .T_HOLD_CYC (T_HOLD),
        .T_EXEC_CYC (T_EXEC),
        .T_LONG_CYC (T_LONG)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_rs   (req0_rs),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rs   (req1_rs),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .RS        (RS),
        .RW        (RW),
        .E         (E),
        .DB        (DB),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic       rs;
        logic [7:0] data;
        int         len;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one byte, then watches the whole write cycle from the accept edge.
    task automatic run_txn(input int id, input logic rs, input logic [7:0] d, input int len);
        int k, first_e, e_cnt, rises, hold_bad;
        logic e_prev;
        @(negedge clock);
        if (id == 0) begin
            req0_rs = rs; req0_data = d; req0_valid = 1'b1;
        end else begin
            req1_rs = rs; req1_data = d; req1_valid = 1'b1;
        end
        #1;
        chk("ready_before_accept", (id == 0) ? req0_ready : req1_ready, 1);
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0; first_e = -1; e_cnt = 0; rises = 0; hold_bad = 0; e_prev = 1'b0;
        while (busy && k < 1000) begin
            if (E) begin
                e_cnt++;
                if (first_e < 0) first_e = k;
            end
            if (E && !e_prev) rises++;
            if (RS !== rs || DB !== d || req0_ready || req1_ready) hold_bad++;
            e_prev = E;
            @(negedge clock);
            k++;
        end
        chk("cycle_len", k, len);
        chk("e_rise_offset", first_e, T_SETUP);
        chk("e_high_cycles", e_cnt, T_EPW);
        chk("e_pulse_count", rises, 1);
        chk("rs_db_held", hold_bad, 0);
        chk("grant_id", grant_id, id);
        chk("db_after_idle", DB, d);
    endtask

    initial begin
        int k, g0, nrec, acc, pulses, rdy_bad;
        logic e_prev;
        int order[6];
        int exp_order[6];

        vecs[0] = '{1, 1'b1, 8'h41, SHORT_LEN};
        vecs[1] = '{0, 1'b0, 8'h01, LONG_LEN};
        vecs[2] = '{0, 1'b0, 8'h38, SHORT_LEN};
        vecs[3] = '{0, 1'b1, 8'h01, SHORT_LEN};
        vecs[4] = '{0, 1'b0, 8'h02, LONG_LEN};
        vecs[5] = '{1, 1'b0, 8'h03, LONG_LEN};
        vecs[6] = '{0, 1'b0, 8'h00, SHORT_LEN};
        vecs[7] = '{1, 1'b0, 8'h04, SHORT_LEN};
`ifdef LCD_SEQ_STARVE_GUARD_EN
        exp_order = '{0, 0, 0, 1, 0, 0};
`else
        exp_order = '{0, 0, 0, 0, 0, 1};
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_RS", RS, 0);
        chk("rst_RW", RW, 0);
        chk("rst_E", E, 0);
        chk("rst_DB", DB, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready0", req0_ready, 0);
        chk("idle_ready1", req1_ready, 0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].id, vecs[i].rs, vecs[i].data, vecs[i].len);
        end

        // Both requesters valid: requester 0 wins, requester 1 follows once 0 drops.
        @(negedge clock);
        req0_rs = 1'b1; req0_data = 8'h50; req0_valid = 1'b1;
        req1_rs = 1'b1; req1_data = 8'h51; req1_valid = 1'b1;
        #1;
        chk("arb_ready0", req0_ready, 1);
        chk("arb_ready1", req1_ready, 0);
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        chk("arb_grant0", grant_id, 0);
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("arb_len0", k, SHORT_LEN);
        chk("arb_ready1_after", req1_ready, 1);
        @(posedge clock);
        @(negedge clock);
        req1_valid = 1'b0;
        chk("arb_grant1", grant_id, 1);
        chk("arb_db1", DB, 8'h51);
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("arb_len1", k, SHORT_LEN);

        // Reset during the E pulse.
        @(negedge clock);
        req1_rs = 1'b1; req1_data = 8'h41; req1_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req1_valid = 1'b0;
        k = 0;
        while (!E && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("midpulse_e_seen", E, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midpulse_rst_E", E, 0);
        chk("midpulse_rst_busy", busy, 0);
        chk("midpulse_rst_DB", DB, 0);
        @(negedge clock);
        reset = 1'b0;

        // Requester 0 streams 5 bytes while requester 1 stays valid.
        @(negedge clock);
        req0_rs = 1'b1; req0_data = 8'h30; req0_valid = 1'b1;
        req1_rs = 1'b1; req1_data = 8'h71; req1_valid = 1'b1;
        g0 = 0; nrec = 0; k = 0;
        while (nrec < 6 && k < 2000) begin
            #1;
            if (req0_ready) begin
                order[nrec] = 0;
                nrec++;
                g0++;
                @(negedge clock);
                req0_data = 8'h30 + 8'(g0);
                if (g0 == 5) req0_valid = 1'b0;
            end else if (req1_ready) begin
                order[nrec] = 1;
                nrec++;
                @(negedge clock);
                req1_valid = 1'b0;
            end else begin
                @(negedge clock);
            end
            k++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("starve_grants", nrec, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < nrec) chk($sformatf("starve_order_%0d", i), order[i], exp_order[i]);
        end
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clock);
            k++;
        end

        // Ten back-to-back requester-1 bytes.
        @(negedge clock);
        req1_rs = 1'b1; req1_data = 8'h60; req1_valid = 1'b1;
        acc = 0; pulses = 0; rdy_bad = 0; e_prev = 1'b0; k = 0;
        while (!(acc == 10 && !req1_valid && !busy) && k < 2000) begin
            #1;
            if (E && !e_prev) pulses++;
            e_prev = E;
            if (busy && (req0_ready || req1_ready)) rdy_bad++;
            if (acc == 10) begin
                req1_valid = 1'b0;
            end else if (req1_ready) begin
                acc++;
            end else begin
                req1_data = 8'h60 + 8'(acc);
            end
            @(negedge clock);
            k++;
        end
        chk("b2b_timeout", (k < 2000) ? 1 : 0, 1);
        chk("b2b_accepts", acc, 10);
        chk("b2b_pulses", pulses, 10);
        chk("b2b_ready_while_busy", rdy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
